regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 99 +++++++++
 tb/tb_regfile_writeback.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue merging load and ALU results onto one register-file write port
module regfile_writeback #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_valid,
   input  logic [2:0]                 mem_addr,
   input  logic [DW-1:0]              mem_data,
   output logic                       mem_ready,
   input  logic                       alu_valid,
   input  logic [2:0]                 alu_addr,
   input  logic [DW-1:0]              alu_data,
   output logic                       alu_ready,
   output logic                       WE3,
   output logic [2:0]                 A3,
   output logic [DW-1:0]              WD3,
   input  logic [2:0]                 lk1_addr,
   input  logic [2:0]                 lk2_addr,
   output logic                       lk1_hit,
   output logic                       lk2_hit,
   output logic [DW-1:0]              lk1_data,
   output logic [DW-1:0]              lk2_data,
   output logic [$clog2(DEPTH):0]     pend_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [2:0]    addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, wp_alu;
   logic [PW:0]   cnt_q, cnt_d, free;
   logic          mem_en, alu_en, pop;

   // Readiness from start-of-cycle occupancy; writes to r0 handshake but are dropped
   always_comb begin
      free      = DEPTH_C - cnt_q;
      mem_ready = free != '0;
      alu_ready = mem_valid ? free >= (PW+1)'(2) : free != '0;
      mem_en    = mem_valid & mem_ready & (mem_addr != 3'd0);
      alu_en    = alu_valid & alu_ready & (alu_addr != 3'd0);
      pop       = cnt_q != '0;
      wp_alu    = wp_q + PW'(mem_en);
      wp_d      = wp_alu + PW'(alu_en);
      rp_d      = rp_q + PW'(pop);
      cnt_d     = cnt_q + (PW+1)'(mem_en) + (PW+1)'(alu_en) - (PW+1)'(pop);
      WE3       = pop;
      A3        = pop ? addr_q[rp_q] : 3'd0;
      WD3       = pop ? data_q[rp_q] : '0;
   end

   // Pointer and occupancy state; reset discards every pending write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; mem lands in the older slot when both enqueue together
   always_ff @(posedge clk) begin
      if (mem_en) begin
         addr_q[wp_q] <= mem_addr;
         data_q[wp_q] <= mem_data;
      end
      if (alu_en) begin
         addr_q[wp_alu] <= alu_addr;
         data_q[wp_alu] <= alu_data;
      end
   end

   // Forwarding lookup, scanning oldest to youngest so the youngest match wins
   always_comb begin
      lk1_hit  = 1'b0;
      lk1_data = '0;
      lk2_hit  = 1'b0;
      lk2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((PW+1)'(k) < cnt_q) begin
            if (lk1_addr != 3'd0 && addr_q[rp_q + PW'(k)] == lk1_addr) begin
               lk1_hit  = 1'b1;
               lk1_data = data_q[rp_q + PW'(k)];
            end
            if (lk2_addr != 3'd0 && addr_q[rp_q + PW'(k)] == lk2_addr) begin
               lk2_hit  = 1'b1;
               lk2_data = data_q[rp_q + PW'(k)];
            end
         end
      end
   end

   assign pend_count = cnt_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized bench with a queue-based reference model of the write-back buffer
module tb_regfile_writeback;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_valid, alu_valid;
   logic [2:0]    mem_addr, alu_addr, lk1_addr, lk2_addr, A3;
   logic [DW-1:0] mem_data, alu_data, WD3, lk1_data, lk2_data;
   logic          mem_ready, alu_ready, WE3, lk1_hit, lk2_hit;
   logic [2:0]    pend_count;

   typedef struct packed {
      logic [2:0]    a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   regfile_writeback #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .WE3(WE3), .A3(A3), .WD3(WD3),
      .lk1_addr(lk1_addr), .lk2_addr(lk2_addr),
      .lk1_hit(lk1_hit), .lk2_hit(lk2_hit), .lk1_data(lk1_data), .lk2_data(lk2_data),
      .pend_count(pend_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW:0] look(input logic [2:0] la);
      for (int i = q.size() - 1; i >= 0; i--)
         if (la != 3'd0 && q[i].a == la) return {1'b1, q[i].d};
      return '0;
   endfunction

   // Reference: what the queue holds after this edge, from the acceptance rules
   task automatic model_update();
      int  fr;
      bit  mr, ar;
      fr = DEPTH - q.size();
      mr = fr >= 1;
      ar = mem_valid ? fr >= 2 : fr >= 1;
      if (q.size() != 0) void'(q.pop_front());
      if (mem_valid && mr && mem_addr != 3'd0) q.push_back({mem_addr, mem_data});
      if (alu_valid && ar && alu_addr != 3'd0) q.push_back({alu_addr, alu_data});
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic idle();
      mem_valid = 1'b0;
      alu_valid = 1'b0;
   endtask

   // Compare every cycle against the model, away from the active edge
   always @(negedge clk) begin
      int         n, fr;
      logic [DW:0] e1, e2;
      n  = q.size();
      fr = DEPTH - n;
      e1 = look(lk1_addr);
      e2 = look(lk2_addr);
      chk("mem_ready", 32'(mem_ready), 32'(fr >= 1));
      chk("alu_ready", 32'(alu_ready), 32'(mem_valid ? fr >= 2 : fr >= 1));
      chk("WE3", 32'(WE3), 32'(n != 0));
      chk("A3", 32'(A3), n != 0 ? 32'(q[0].a) : 32'd0);
      chk("WD3", 32'(WD3), n != 0 ? 32'(q[0].d) : 32'd0);
      chk("pend_count", 32'(pend_count), 32'(n));
      chk("lk1", {15'd0, lk1_hit, lk1_data}, 32'(e1));
      chk("lk2", {15'd0, lk2_hit, lk2_data}, 32'(e2));
   end

   initial begin
      rst = 1'b0;
      idle();
      mem_addr = 3'd0; alu_addr = 3'd0; mem_data = '0; alu_data = '0;
      lk1_addr = 3'd0; lk2_addr = 3'd0;
      mem_valid = 1'b1; alu_valid = 1'b1; mem_addr = 3'd3; alu_addr = 3'd4;
      step(); step();
      @(negedge clk);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      chk("rst_pend", 32'(pend_count), 32'd0);
      chk("rst_WE3", 32'(WE3), 32'd0);
      idle();
      step();
      rst = 1'b1;

      // single write
      mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h1234;
      step();
      idle();
      @(negedge clk);
      chk("single_WE3", 32'(WE3), 32'd1);
      chk("single_A3", 32'(A3), 32'd5);
      chk("single_WD3", 32'(WD3), 32'h1234);
      chk("single_pend", 32'(pend_count), 32'd1);
      step();
      @(negedge clk);
      chk("single_after", 32'(WE3), 32'd0);

      // dual accept, same address
      mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'hAAAA;
      alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'hBBBB;
      lk1_addr = 3'd2;
      step();
      idle();
      @(negedge clk);
      chk("dual_first", 32'(WD3), 32'hAAAA);
      chk("dual_lk", {15'd0, lk1_hit, lk1_data}, {15'd0, 1'b1, 16'hBBBB});
      step();
      @(negedge clk);
      chk("dual_second", 32'(WD3), 32'hBBBB);
      step();

      // r0 drop
      alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'hFFFF; lk1_addr = 3'd0;
      step();
      idle();
      @(negedge clk);
      chk("r0_WE3", 32'(WE3), 32'd0);
      chk("r0_pend", 32'(pend_count), 32'd0);
      chk("r0_lk", 32'(lk1_hit), 32'd0);

      // fill toward full with both sources held
      mem_valid = 1'b1; alu_valid = 1'b1; mem_addr = 3'd3; alu_addr = 3'd6; lk1_addr = 3'd6;
      for (int i = 0; i < 6; i++) begin
         mem_data = 16'($urandom);
         alu_data = 16'($urandom);
         step();
         chk("full_bound", 32'(pend_count <= 3'd4), 32'd1);
      end
      idle();
      repeat (5) step();

      // ten back-to-back single writes to exercise pointer wrap
      for (int i = 0; i < 10; i++) begin
         mem_valid = 1'b1;
         mem_addr  = 3'($urandom_range(1, 7));
         mem_data  = 16'($urandom);
         step();
      end
      idle();
      repeat (3) step();

      // random traffic with a small address set to stress youngest-match
      for (int i = 0; i < 400; i++) begin
         mem_valid = 1'($urandom);
         alu_valid = 1'($urandom);
         mem_addr  = 3'($urandom_range(0, 3));
         alu_addr  = 3'($urandom_range(0, 3));
         mem_data  = 16'($urandom);
         alu_data  = 16'($urandom);
         lk1_addr  = 3'($urandom_range(0, 3));
         lk2_addr  = 3'($urandom_range(0, 7));
         step();
      end
      idle();
      repeat (5) step();

      // reset mid-flight with three entries queued
      mem_valid = 1'b1; alu_valid = 1'b1; mem_addr = 3'd1; alu_addr = 3'd7;
      mem_data = 16'h1111; alu_data = 16'h7777;
      step(); step();
      idle();
      chk("pre_rst_pend", 32'(pend_count), 32'd3);
      rst = 1'b0;
      q.delete();
      #1;
      chk("midrst_WE3", 32'(WE3), 32'd0);
      chk("midrst_pend", 32'(pend_count), 32'd0);
      step();
      rst = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("post_rst_WE3", 32'(WE3), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
